// File: rtl/read_op.sv
// DDR read engine: issues a burst of single-beat reads from a base address and
// forwards returned beats in order, with a cap on requests in flight.
module read_op #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 8,
    parameter int ADDR_STEP = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rd_ddr_en_i,
    input  logic [ADDR_W-1:0] rd_ddr_addr_i,
    input  logic [LEN_W-1:0]  rd_ddr_len_i,
    output logic              ddr_rd_req_o,
    output logic [ADDR_W-1:0] ddr_rd_addr_o,
    input  logic              ddr_rd_ack_i,
    input  logic              ddr_rd_valid_i,
    input  logic [DATA_W-1:0] ddr_rd_data_i,
    output logic              rd_data_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_ddr_done_o,
    output logic              busy_o
);

    localparam int                OUT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  received_q;
    logic [OUT_W-1:0]  outst_q;
    logic              start;
    logic              req;
    logic              issue;
    logic              accept;

    assign start  = (state_q == S_IDLE) && rd_ddr_en_i;
    assign req    = (state_q == S_RUN) && (issued_q < len_q) && (outst_q < OUT_MAX);
    assign issue  = req && ddr_rd_ack_i;
    // A return with nothing in flight is stray (e.g. left over from before a reset).
    assign accept = ddr_rd_valid_i && (outst_q != '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (rd_ddr_en_i) state_q <= (rd_ddr_len_i != '0) ? S_RUN : S_DONE;
                S_RUN:  if (received_q == len_q) state_q <= S_DONE;
                S_DONE: state_q <= S_HOLD;
                default: if (!rd_ddr_en_i) state_q <= S_IDLE;
            endcase
        end
    end

    // The request address advances with each accepted request, so no multiply is needed.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
        end else if (start) begin
            addr_q   <= rd_ddr_addr_i;
            len_q    <= rd_ddr_len_i;
            issued_q <= '0;
        end else if (issue) begin
            addr_q   <= addr_q + STEP;
            issued_q <= issued_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            received_q <= '0;
            outst_q    <= '0;
        end else if (start) begin
            received_q <= '0;
            outst_q    <= '0;
        end else begin
            if (accept) received_q <= received_q + 1'b1;
            case ({issue, accept})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data_valid_o <= 1'b0;
            rd_data_o       <= '0;
        end else begin
            rd_data_valid_o <= accept;
            if (accept) rd_data_o <= ddr_rd_data_i;
        end
    end

    assign ddr_rd_req_o  = req;
    assign ddr_rd_addr_o = addr_q;
    assign rd_ddr_done_o = (state_q == S_DONE);
    assign busy_o        = (state_q == S_RUN);

endmodule

// File: tb/tb_read_op.sv
// Bench for read_op: a DDR responder model feeds returns, a scoreboard checks
// request addresses and returned beats, and a directed sequence covers each scenario.
module tb_read_op;

    logic         clk = 1'b0;
    logic         rstn_i = 1'b0;
    logic         rd_ddr_en_i = 1'b0;
    logic [29:0]  rd_ddr_addr_i = '0;
    logic [7:0]   rd_ddr_len_i = '0;
    logic         ddr_rd_req_o;
    logic [29:0]  ddr_rd_addr_o;
    logic         ddr_rd_ack_i = 1'b0;
    logic         ddr_rd_valid_i = 1'b0;
    logic [255:0] ddr_rd_data_i = '0;
    logic         rd_data_valid_o;
    logic [255:0] rd_data_o;
    logic         rd_ddr_done_o;
    logic         busy_o;

    always #5 clk = ~clk;

    read_op #(.ADDR_W(30), .DATA_W(256), .LEN_W(8), .ADDR_STEP(32), .MAX_OUTST(4)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .rd_ddr_en_i(rd_ddr_en_i), .rd_ddr_addr_i(rd_ddr_addr_i), .rd_ddr_len_i(rd_ddr_len_i),
        .ddr_rd_req_o(ddr_rd_req_o), .ddr_rd_addr_o(ddr_rd_addr_o), .ddr_rd_ack_i(ddr_rd_ack_i),
        .ddr_rd_valid_i(ddr_rd_valid_i), .ddr_rd_data_i(ddr_rd_data_i),
        .rd_data_valid_o(rd_data_valid_o), .rd_data_o(rd_data_o),
        .rd_ddr_done_o(rd_ddr_done_o), .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] beat_of(input logic [29:0] a);
        return {8{2'b10, a}};
    endfunction

    // Responder and scoreboard state
    int           cyc = 0;
    int           lat = 3;
    int           n_acc = 0;
    int           mdl_outst = 0;
    int           stall_req = -1;
    int           stall_left = 0;
    bit           stall_active = 0;
    logic [29:0]  stall_addr = '0;
    bit           stray = 0;
    int           ret_t[$];
    logic [29:0]  ret_a[$];
    logic [255:0] exp_q[$];
    logic [29:0]  exp_addr[$];
    int           n_beats = 0;
    int           done_cnt = 0;
    int           req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // DDR model: acts on the falling edge so its inputs are stable at the next rising edge.
    always @(negedge clk) begin
        int t;
        ddr_rd_valid_i = 1'b0;
        if (stray) begin
            ddr_rd_valid_i = 1'b1;
            ddr_rd_data_i  = {8{32'hDEAD_BEEF}};
            stray = 0;
        end else if (ret_t.size() > 0 && ret_t[0] <= cyc) begin
            ddr_rd_valid_i = 1'b1;
            ddr_rd_data_i  = beat_of(ret_a[0]);
            exp_q.push_back(beat_of(ret_a[0]));
            void'(ret_t.pop_front());
            void'(ret_a.pop_front());
            mdl_outst--;
        end
        ddr_rd_ack_i = 1'b1;
        if (stall_left > 0 && n_acc == stall_req && (ddr_rd_req_o || stall_active)) begin
            stall_active = 1;
            ddr_rd_ack_i = 1'b0;
            stall_left--;
            chk("stall_req_held", 32'(ddr_rd_req_o), 32'd1);
            chk("stall_addr_held", 32'(ddr_rd_addr_o), 32'(stall_addr));
        end else if (ddr_rd_req_o) begin
            chk("req_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
                chk("req_addr", 32'(ddr_rd_addr_o), 32'(exp_addr[0]));
                void'(exp_addr.pop_front());
            end
            n_acc++;
            mdl_outst++;
            chk("outst_limit", 32'(mdl_outst <= 4), 32'd1);
            t = cyc + lat;
            if (ret_t.size() > 0 && t <= ret_t[$]) t = ret_t[$] + 1;
            ret_t.push_back(t);
            ret_a.push_back(ddr_rd_addr_o);
        end
        if (stall_left == 0) stall_active = 0;
    end

    always @(negedge clk) begin
        if (rd_data_valid_o) begin
            n_beats++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk_d("beat_data", rd_data_o, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        if (rd_ddr_done_o) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy_o), 32'd0);
        end
        if (ddr_rd_req_o) req_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [29:0] a, input logic [7:0] l);
        n_acc = 0;
        exp_addr.delete();
        for (int i = 0; i < int'(l); i++) exp_addr.push_back(a + 30'(i * 32));
        rd_ddr_addr_i = a;
        rd_ddr_len_i  = l;
        rd_ddr_en_i   = 1'b1;
        tick();
        rd_ddr_en_i   = 1'b0;
        rd_ddr_addr_i = 30'h3FFF_FFFF;
        rd_ddr_len_i  = 8'hFF;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic burst_chk(input string tag, input int beats0, input int done0, input int len);
        tick();
        chk({tag, "_beats"}, 32'(n_beats - beats0), 32'(len));
        chk({tag, "_reqs"}, 32'(n_acc), 32'(len));
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_beat_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done_once"}, 32'(done_cnt - done0), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int b0;
        int d0;
        int r0;
        int k;

        // Reset state
        repeat (3) tick();
        chk("rst_req", 32'(ddr_rd_req_o), 32'd0);
        chk("rst_addr", 32'(ddr_rd_addr_o), 32'd0);
        chk("rst_valid", 32'(rd_data_valid_o), 32'd0);
        chk_d("rst_data", rd_data_o, '0);
        chk("rst_done", 32'(rd_ddr_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rstn_i = 1'b1;
        repeat (2) tick();

        // Basic burst
        b0 = n_beats; d0 = done_cnt; lat = 3;
        start(30'h100, 8'd4);
        chk("basic_busy", 32'(busy_o), 32'd1);
        wait_done(200);
        burst_chk("basic", b0, d0, 4);

        // Throttling on outstanding requests
        b0 = n_beats; d0 = done_cnt; lat = 20;
        start(30'h2000, 8'd10);
        repeat (15) tick();
        chk("throttle_issued", 32'(n_acc), 32'd4);
        chk("throttle_req_low", 32'(ddr_rd_req_o), 32'd0);
        wait_done(400);
        burst_chk("throttle", b0, d0, 10);

        // Ack stall on the second request
        b0 = n_beats; d0 = done_cnt; lat = 3;
        stall_req = 1; stall_left = 5; stall_addr = 30'h420;
        start(30'h400, 8'd3);
        wait_done(200);
        burst_chk("stall", b0, d0, 3);
        chk("stall_consumed", 32'(stall_left), 32'd0);
        stall_req = -1;

        // Zero length: done without requests, no retrigger while en stays high
        d0 = done_cnt; r0 = req_seen;
        rd_ddr_addr_i = 30'h500; rd_ddr_len_i = 8'd0; rd_ddr_en_i = 1'b1;
        tick();
        chk("len0_done_pulse", 32'(rd_ddr_done_o), 32'd1);
        chk("len0_busy", 32'(busy_o), 32'd0);
        tick();
        chk("len0_done_1cyc", 32'(rd_ddr_done_o), 32'd0);
        repeat (5) tick();
        chk("len0_no_retrigger", 32'(done_cnt - d0), 32'd1);
        chk("len0_no_req", 32'(req_seen - r0), 32'd0);
        rd_ddr_en_i = 1'b0;
        repeat (2) tick();
        b0 = n_beats;
        start(30'h500, 8'd1);
        wait_done(100);
        tick();
        chk("len0_restart", 32'(done_cnt - d0), 32'd2);
        chk("len0_restart_beat", 32'(n_beats - b0), 32'd1);

        // Address wrap at the top of the address space
        b0 = n_beats; d0 = done_cnt;
        start(30'h3FFF_FFF0, 8'd2);
        wait_done(100);
        burst_chk("wrap", b0, d0, 2);

        // Reset in the middle of a burst
        lat = 20;
        start(30'h1000, 8'd8);
        k = 0;
        while (n_acc < 3 && k < 50) begin
            tick();
            k++;
        end
        chk("mid_acks_seen", 32'(n_acc >= 3), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        chk("mid_rst_req", 32'(ddr_rd_req_o), 32'd0);
        chk("mid_rst_addr", 32'(ddr_rd_addr_o), 32'd0);
        chk("mid_rst_valid", 32'(rd_data_valid_o), 32'd0);
        chk_d("mid_rst_data", rd_data_o, '0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(rd_ddr_done_o), 32'd0);
        ret_t.delete(); ret_a.delete(); exp_q.delete(); exp_addr.delete();
        mdl_outst = 0;
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
        b0 = n_beats;
        stray = 1;
        tick();
        chk("stray_ignored", 32'(rd_data_valid_o), 32'd0);
        tick();
        chk("stray_no_beat", 32'(n_beats - b0), 32'd0);
        d0 = done_cnt; lat = 3;
        start(30'h800, 8'd3);
        wait_done(200);
        burst_chk("post_rst", b0, d0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
